// File: rtl/rgb_to_gray_pkg.sv
// Shared constants and types for the RGB-to-gray streaming converter.
// Luma weights sum to 256, so the weighted sum shifted right by 8 always fits a byte.
package rgb_to_gray_pkg;

  localparam int unsigned COEF_R      = 77;
  localparam int unsigned COEF_G      = 150;
  localparam int unsigned COEF_B      = 29;
  localparam int unsigned GRAY_SHIFT  = 8;
  localparam int unsigned ROUND_CONST = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic logic [15:0] mulCoef(input logic [7:0] chan, input logic [7:0] coef);
    return 16'(chan) * 16'(coef);
  endfunction

endpackage

// File: rtl/rgb_to_gray_pipe.sv
// Two-stage gray datapath: S1 registers the weighted channel products, S2 the scaled sum.
// Define GRAY_ROUND_EN to round half-up instead of truncating.
module rgb_to_gray_pipe
  import rgb_to_gray_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        advance,
  input  logic        inValid,
  input  logic [23:0] inPixel,
  output logic        s1Valid,
  output logic        outValid,
  output logic [7:0]  outGray
);

`ifdef GRAY_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [15:0] ROUND_ADD = ROUND_EN ? 16'(ROUND_CONST) : 16'd0;

  logic [15:0] prodR;
  logic [15:0] prodG;
  logic [15:0] prodB;
  logic [15:0] sum;

  // Worst case 256*255 + 128 = 65408, so the 16-bit sum cannot overflow.
  assign sum = prodR + prodG + prodB + ROUND_ADD;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1Valid <= 1'b0;
      prodR   <= '0;
      prodG   <= '0;
      prodB   <= '0;
    end else if (advance) begin
      s1Valid <= inValid;
      if (inValid) begin
        prodR <= mulCoef(inPixel[23:16], 8'(COEF_R));
        prodG <= mulCoef(inPixel[15:8],  8'(COEF_G));
        prodB <= mulCoef(inPixel[7:0],   8'(COEF_B));
      end
    end
  end

  // Output only moves on advance, which keeps it frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outValid <= 1'b0;
      outGray  <= '0;
    end else if (advance) begin
      outValid <= s1Valid;
      if (s1Valid) begin
        outGray <= 8'(sum >> GRAY_SHIFT);
      end
    end
  end

endmodule

// File: rtl/rgb_to_gray_stream.sv
// Avalon-ST RGB frame to gray pixel stream with frame tracking and sticky framing error.
// Optional GRAY_ROUND_EN selects round-half-up in the datapath.
module rgb_to_gray_stream
  import rgb_to_gray_pkg::*;
#(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] SinkData_i,
  input  logic        sinkValid_i,
  input  logic        sinkSop_i,
  input  logic        sinkEop_i,
  output logic        sinkReady_o,
  output logic [7:0]  GrayImg_o,
  output logic        grayValid_o,
  input  logic        grayReady_i,
  output logic        frameDone_o,
  output logic        frameErr_o
);

  localparam int N     = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N);

  state_t           stateReg;
  state_t           stateNext;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] countNext;
  logic [CNT_W-1:0] beatCount;
  logic             errReg;
  logic             errNext;
  logic             doneReg;
  logic             doneNext;

  logic advance;
  logic accepted;
  logic forward;
  logic s1Valid;
  logic pipeEmpty;

  assign advance     = !grayValid_o || grayReady_i;
  assign sinkReady_o = (stateReg != FLUSH) && advance;
  assign accepted    = sinkValid_i && sinkReady_o;
  // Nothing is accepted in FLUSH, so only stray non-sop beats in IDLE are dropped.
  assign forward     = accepted && ((stateReg == ACTIVE) || sinkSop_i);
  assign pipeEmpty   = !s1Valid && !grayValid_o;

  rgb_to_gray_pipe uPipe (
    .clk      (clk_i),
    .rstN     (rst_i),
    .advance  (advance),
    .inValid  (forward),
    .inPixel  (SinkData_i),
    .s1Valid  (s1Valid),
    .outValid (grayValid_o),
    .outGray  (GrayImg_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateReg <= IDLE;
      countReg <= '0;
      errReg   <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      errReg   <= errNext;
      doneReg  <= doneNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    errNext   = errReg;
    doneNext  = 1'b0;
    beatCount = sinkSop_i ? CNT_W'(1) : countReg + CNT_W'(1);

    case (stateReg)
      IDLE: begin
        if (accepted && sinkSop_i) begin
          errNext   = 1'b0;
          countNext = beatCount;
          stateNext = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accepted) begin
          countNext = beatCount;
          if (sinkSop_i) begin
            errNext = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (pipeEmpty) begin
          doneNext  = 1'b1;
          countNext = '0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Frame end: either the pixel budget is reached or eop arrives; anything but both together is an error.
    if (forward) begin
      if (beatCount == LAST) begin
        stateNext = FLUSH;
        if (!sinkEop_i) begin
          errNext = 1'b1;
        end
      end else if (sinkEop_i) begin
        stateNext = FLUSH;
        errNext   = 1'b1;
      end
    end
  end

  assign frameDone_o = doneReg;
  assign frameErr_o  = errReg;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Self-checking bench for rgb_to_gray_stream on a 4x4 image with a frame-level reference model.
// Honors GRAY_ROUND_EN for the expected gray values.
module tb_rgb_to_gray_stream;

  localparam int NPIX = 16;

  logic        clk_i;
  logic        rst_i;
  logic [23:0] SinkData_i;
  logic        sinkValid_i;
  logic        sinkSop_i;
  logic        sinkEop_i;
  logic        sinkReady_o;
  logic [7:0]  GrayImg_o;
  logic        grayValid_o;
  logic        grayReady_i;
  logic        frameDone_o;
  logic        frameErr_o;

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t accQ[$];
  int    gotQ[$];
  int    expQ[$];
  int    expDone;
  logic  expErr;
  int    doneCnt;
  int    nChecks = 0;
  int    nFails  = 0;
  bit    randReady = 0;

  rgb_to_gray_stream #(
    .IMG_X_SIZE (4),
    .IMG_Y_SIZE (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .SinkData_i  (SinkData_i),
    .sinkValid_i (sinkValid_i),
    .sinkSop_i   (sinkSop_i),
    .sinkEop_i   (sinkEop_i),
    .sinkReady_o (sinkReady_o),
    .GrayImg_o   (GrayImg_o),
    .grayValid_o (grayValid_o),
    .grayReady_i (grayReady_i),
    .frameDone_o (frameDone_o),
    .frameErr_o  (frameErr_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Observe handshakes mid-cycle, where inputs and outputs are settled for the next edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (sinkValid_i && sinkReady_o) accQ.push_back('{SinkData_i, sinkSop_i, sinkEop_i});
        if (grayValid_o && grayReady_i) gotQ.push_back(int'(GrayImg_o));
        if (frameDone_o) doneCnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (randReady) grayReady_i = 1'($urandom_range(0, 1));
    end
  end

  function automatic int grayOf(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    return s / 256;
  endfunction

  // Frame semantics over the list of accepted beats: a frame opens on sop, closes on the
  // NPIX-th pixel or on eop, and is clean only when both coincide.
  task automatic runModel();
    int cnt;
    bit inFrame;
    expQ.delete();
    expDone = 0;
    expErr  = 1'b0;
    cnt     = 0;
    inFrame = 0;
    foreach (accQ[i]) begin
      if (!inFrame && !accQ[i].sop) continue;
      expQ.push_back(grayOf(accQ[i].d));
      if (!inFrame) begin
        inFrame = 1;
        expErr  = 1'b0;
        cnt     = 1;
      end else if (accQ[i].sop) begin
        expErr = 1'b1;
        cnt    = 1;
      end else begin
        cnt++;
      end
      if (cnt == NPIX || accQ[i].eop) begin
        if (!(cnt == NPIX && accQ[i].eop)) expErr = 1'b1;
        inFrame = 0;
        expDone++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sendBeat(input logic [23:0] d, input logic sop, input logic eop);
    logic acc;
    int guard;
    SinkData_i  = d;
    sinkSop_i   = sop;
    sinkEop_i   = eop;
    sinkValid_i = 1'b1;
    guard = 0;
    do begin
      @(negedge clk_i);
      acc = sinkReady_o;
      step();
      guard++;
    end while (!acc && guard < 200);
    nChecks++;
    if (!acc) begin
      nFails++;
      $display("FAIL beat_timeout: sinkReady_o stayed %0b, required 1 within 200 cycles", acc);
    end
    sinkValid_i = 1'b0;
    sinkSop_i   = 1'b0;
    sinkEop_i   = 1'b0;
  endtask

  task automatic sendPix(input int n, input int eopAt, input bit firstSop, input int gapMax);
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, gapMax)) step();
      sendBeat(24'($urandom()), firstSop && (i == 1), i == eopAt);
    end
  endtask

  task automatic drain();
    randReady = 0;
    step();
    grayReady_i = 1'b1;
    repeat (12) step();
  endtask

  task automatic doReset();
    sinkValid_i = 1'b0;
    sinkSop_i   = 1'b0;
    sinkEop_i   = 1'b0;
    grayReady_i = 1'b1;
    rst_i       = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    step();
    accQ.delete();
    gotQ.delete();
    doneCnt = 0;
  endtask

  task automatic test_reset();
    sinkValid_i = 1'b0;
    sinkSop_i   = 1'b0;
    sinkEop_i   = 1'b0;
    SinkData_i  = '0;
    grayReady_i = 1'b1;
    rst_i       = 1'b0;
    step();
    step();
    nChecks++; if (grayValid_o !== 1'b0) begin nFails++; $display("FAIL reset_grayValid: got %0b required 0", grayValid_o); end
    nChecks++; if (GrayImg_o !== 8'd0) begin nFails++; $display("FAIL reset_gray: got %0d required 0", GrayImg_o); end
    nChecks++; if (frameDone_o !== 1'b0) begin nFails++; $display("FAIL reset_done: got %0b required 0", frameDone_o); end
    nChecks++; if (frameErr_o !== 1'b0) begin nFails++; $display("FAIL reset_err: got %0b required 0", frameErr_o); end
    rst_i = 1'b1;
    #1;
    nChecks++; if (sinkReady_o !== 1'b1) begin nFails++; $display("FAIL reset_ready: got %0b required 1", sinkReady_o); end
    $display("test_reset done");
  endtask

  task automatic test_known();
    logic [7:0] exp3;
    exp3 = 8'(grayOf(24'hFF0000));
    doReset();
    SinkData_i = 24'hFFFFFF; sinkSop_i = 1'b1; sinkValid_i = 1'b1;
    step();
    SinkData_i = 24'h000000; sinkSop_i = 1'b0;
    step();
    nChecks++; if (grayValid_o !== 1'b1 || GrayImg_o !== 8'd255) begin nFails++; $display("FAIL known_white: got v=%0b %0d required v=1 255", grayValid_o, GrayImg_o); end
    SinkData_i = 24'hFF0000;
    step();
    nChecks++; if (grayValid_o !== 1'b1 || GrayImg_o !== 8'd0) begin nFails++; $display("FAIL known_black: got v=%0b %0d required v=1 0", grayValid_o, GrayImg_o); end
    sinkValid_i = 1'b0;
    step();
    nChecks++; if (grayValid_o !== 1'b1 || GrayImg_o !== exp3) begin nFails++; $display("FAIL known_red: got v=%0b %0d required v=1 %0d", grayValid_o, GrayImg_o, exp3); end
    nChecks++; if (exp3 !== 8'(`ifdef GRAY_ROUND_EN 77 `else 76 `endif)) begin nFails++; $display("FAIL known_red_model: got %0d", exp3); end
    step();
    nChecks++; if (grayValid_o !== 1'b0) begin nFails++; $display("FAIL known_empty: got v=%0b required 0", grayValid_o); end
    $display("test_known done");
  endtask

  task automatic test_no_sop();
    doReset();
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (sinkReady_o !== 1'b1) begin nFails++; $display("FAIL nosop_ready: beat %0d got %0b required 1", i, sinkReady_o); end
      sendBeat(24'($urandom()), 1'b0, 1'b0);
    end
    drain();
    nChecks++; if (gotQ.size() !== 0) begin nFails++; $display("FAIL nosop_outputs: got %0d required 0", gotQ.size()); end
    nChecks++; if (doneCnt !== 0) begin nFails++; $display("FAIL nosop_done: got %0d required 0", doneCnt); end
    $display("test_no_sop done: %0d beats accepted", accQ.size());
  endtask

  task automatic test_full_frame();
    doReset();
    sendPix(NPIX, NPIX, 1, 0);
    drain();
    runModel();
    nChecks++; if (gotQ.size() !== NPIX) begin nFails++; $display("FAIL full_count: got %0d required %0d", gotQ.size(), NPIX); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++; if (gotQ[i] !== expQ[i]) begin nFails++; $display("FAIL full_pix[%0d]: got %0d required %0d", i, gotQ[i], expQ[i]); end
    end
    nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL full_done: got %0d required 1", doneCnt); end
    nChecks++; if (frameErr_o !== 1'b0) begin nFails++; $display("FAIL full_err: got %0b required 0", frameErr_o); end
    $display("test_full_frame done: %0d outputs", gotQ.size());
  endtask

  task automatic test_early_eop();
    doReset();
    sendPix(10, 10, 1, 1);
    drain();
    nChecks++; if (gotQ.size() !== 10) begin nFails++; $display("FAIL early_count: got %0d required 10", gotQ.size()); end
    nChecks++; if (frameErr_o !== 1'b1) begin nFails++; $display("FAIL early_err: got %0b required 1", frameErr_o); end
    nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL early_done: got %0d required 1", doneCnt); end
    sendBeat(24'($urandom()), 1'b1, 1'b0);
    nChecks++; if (frameErr_o !== 1'b0) begin nFails++; $display("FAIL early_clear: got %0b required 0", frameErr_o); end
    sendPix(NPIX - 1, NPIX - 1, 0, 0);
    drain();
    runModel();
    nChecks++; if (gotQ.size() !== expQ.size()) begin nFails++; $display("FAIL early_total: got %0d required %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++; if (gotQ[i] !== expQ[i]) begin nFails++; $display("FAIL early_pix[%0d]: got %0d required %0d", i, gotQ[i], expQ[i]); end
    end
    nChecks++; if (doneCnt !== expDone) begin nFails++; $display("FAIL early_done2: got %0d required %0d", doneCnt, expDone); end
    nChecks++; if (frameErr_o !== expErr) begin nFails++; $display("FAIL early_err2: got %0b required %0b", frameErr_o, expErr); end
    $display("test_early_eop done: %0d outputs", gotQ.size());
  endtask

  task automatic test_backpressure();
    int base;
    int stallAcc;
    doReset();
    fork
      begin
        logic [7:0] held;
        bit haveHeld;
        haveHeld    = 0;
        held        = '0;
        base        = accQ.size();
        grayReady_i = 1'b0;
        repeat (5) begin
          @(negedge clk_i);
          if (grayValid_o) begin
            if (!haveHeld) begin
              held = GrayImg_o;
              haveHeld = 1;
            end else begin
              nChecks++; if (GrayImg_o !== held) begin nFails++; $display("FAIL stall_hold: got %0d required %0d", GrayImg_o, held); end
            end
          end
        end
        step();
        stallAcc = accQ.size() - base;
        nChecks++; if (stallAcc > 2) begin nFails++; $display("FAIL stall_accepts: got %0d required at most 2", stallAcc); end
        grayReady_i = 1'b1;
      end
      sendPix(NPIX, NPIX, 1, 0);
    join
    drain();
    runModel();
    nChecks++; if (gotQ.size() !== NPIX) begin nFails++; $display("FAIL stall_count: got %0d required %0d", gotQ.size(), NPIX); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++; if (gotQ[i] !== expQ[i]) begin nFails++; $display("FAIL stall_pix[%0d]: got %0d required %0d", i, gotQ[i], expQ[i]); end
    end
    nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL stall_done: got %0d required 1", doneCnt); end
    $display("test_backpressure done: %0d accepted during stall", stallAcc);
  endtask

  task automatic test_reset_midframe();
    doReset();
    sendPix(7, 0, 1, 0);
    #2;
    rst_i = 1'b0;
    #1;
    nChecks++; if (grayValid_o !== 1'b0) begin nFails++; $display("FAIL mid_grayValid: got %0b required 0", grayValid_o); end
    nChecks++; if (GrayImg_o !== 8'd0) begin nFails++; $display("FAIL mid_gray: got %0d required 0", GrayImg_o); end
    nChecks++; if (frameDone_o !== 1'b0) begin nFails++; $display("FAIL mid_done: got %0b required 0", frameDone_o); end
    nChecks++; if (frameErr_o !== 1'b0) begin nFails++; $display("FAIL mid_err: got %0b required 0", frameErr_o); end
    step();
    #2;
    rst_i = 1'b1;
    accQ.delete();
    gotQ.delete();
    #1;
    nChecks++; if (sinkReady_o !== 1'b1) begin nFails++; $display("FAIL mid_ready: got %0b required 1", sinkReady_o); end
    sendPix(NPIX, NPIX, 1, 1);
    drain();
    runModel();
    nChecks++; if (gotQ.size() !== NPIX) begin nFails++; $display("FAIL mid_count: got %0d required %0d", gotQ.size(), NPIX); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++; if (gotQ[i] !== expQ[i]) begin nFails++; $display("FAIL mid_pix[%0d]: got %0d required %0d", i, gotQ[i], expQ[i]); end
    end
    nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL mid_done2: got %0d required 1", doneCnt); end
    $display("test_reset_midframe done: %0d outputs", gotQ.size());
  endtask

  task automatic test_back_to_back();
    doReset();
    randReady = 1;
    sendPix(NPIX, NPIX, 1, 2);
    sendPix(6, 6, 1, 2);
    sendPix(NPIX, 0, 1, 1);
    sendPix(2, 0, 0, 1);
    sendPix(5, 0, 1, 1);
    sendPix(NPIX, NPIX, 1, 2);
    drain();
    runModel();
    nChecks++; if (gotQ.size() !== expQ.size()) begin nFails++; $display("FAIL b2b_count: got %0d required %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++; if (gotQ[i] !== expQ[i]) begin nFails++; $display("FAIL b2b_pix[%0d]: got %0d required %0d", i, gotQ[i], expQ[i]); end
    end
    nChecks++; if (doneCnt !== expDone) begin nFails++; $display("FAIL b2b_done: got %0d required %0d", doneCnt, expDone); end
    nChecks++; if (frameErr_o !== expErr) begin nFails++; $display("FAIL b2b_err: got %0b required %0b", frameErr_o, expErr); end
    $display("test_back_to_back done: %0d outputs, %0d frames", gotQ.size(), doneCnt);
  endtask

  initial begin
    doneCnt = 0;
    test_reset();
    test_known();
    test_no_sop();
    test_full_frame();
    test_early_eop();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
